// File: rtl/rom_loader_wb.sv
// rom_loader_wb: packs hps_io ioctl halfwords into 32-bit wishbone writes at a fixed
// SDRAM base and shares the SDRAM wishbone port with the core master between downloads.
module rom_loader_wb #(
    parameter logic [7:0]  DL_INDEX  = 8'd1,
    parameter logic [25:0] BASE_ADDR = 26'h400000,
    parameter int unsigned MAX_BYTES = 4194304
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    output logic        ioctl_wait,
    input  logic        core_stb,
    input  logic        core_cyc,
    input  logic        core_we,
    input  logic [3:0]  core_sel,
    input  logic [23:0] core_adr,
    input  logic [31:0] core_dat,
    output logic        core_ack,
    output logic        ram_stb,
    output logic        ram_cyc,
    output logic        ram_we,
    output logic [3:0]  ram_sel,
    output logic [25:0] ram_adr,
    output logic [31:0] ram_dat,
    input  logic        ram_ack,
    output logic        dl_active,
    output logic        dl_done,
    output logic        dl_overrun
);

    typedef enum logic [1:0] {IDLE, HALF, WRITE} state_t;

    state_t      state, state_n;
    logic        dl_req, wr_in_range, wr_ok;
    logic [15:0] low_half, low_half_n;
    logic [22:0] half_word, half_word_n;
    logic [22:0] wr_word, wr_word_n;
    logic [3:0]  wr_sel, wr_sel_n;
    logic [31:0] wr_dat, wr_dat_n;
    logic        held_valid, held_valid_n;
    logic [24:1] held_addr, held_addr_n;
    logic [15:0] held_data, held_data_n;
    logic        start_valid;
    logic [24:1] start_addr;
    logic [15:0] start_data;
    logic        dl_active_n, wait_n, done_n;
    logic [25:0] loader_adr;

    assign dl_req      = ioctl_download && (ioctl_index == DL_INDEX);
    assign wr_in_range = {7'd0, ioctl_addr} < MAX_BYTES;
    assign wr_ok       = ioctl_wr && dl_req && !ioctl_wait && wr_in_range;
    assign loader_adr  = BASE_ADDR + {1'b0, wr_word, 2'b00};

    always_comb begin
        state_n      = state;
        low_half_n   = low_half;
        half_word_n  = half_word;
        wr_word_n    = wr_word;
        wr_sel_n     = wr_sel;
        wr_dat_n     = wr_dat;
        held_valid_n = held_valid;
        held_addr_n  = held_addr;
        held_data_n  = held_data;
        done_n       = 1'b0;
        start_valid  = 1'b0;
        start_addr   = ioctl_addr[24:1];
        start_data   = ioctl_dout;

        case (state)
            IDLE: start_valid = wr_ok;
            HALF: begin
                if (wr_ok) begin
                    if (ioctl_addr[24:2] == half_word) begin
                        if (ioctl_addr[1]) begin
                            wr_word_n = half_word;
                            wr_sel_n  = 4'b1111;
                            wr_dat_n  = {ioctl_dout, low_half};
                            state_n   = WRITE;
                        end else begin
                            low_half_n = ioctl_dout;
                        end
                    end else begin
                        // Different word: flush the lone low half, park the new halfword
                        wr_word_n    = half_word;
                        wr_sel_n     = 4'b0011;
                        wr_dat_n     = {16'h0000, low_half};
                        held_valid_n = 1'b1;
                        held_addr_n  = ioctl_addr[24:1];
                        held_data_n  = ioctl_dout;
                        state_n      = WRITE;
                    end
                end else if (!dl_req) begin
                    wr_word_n = half_word;
                    wr_sel_n  = 4'b0011;
                    wr_dat_n  = {16'h0000, low_half};
                    state_n   = WRITE;
                end
            end
            WRITE: begin
                if (ram_ack && dl_active) begin
                    state_n = IDLE;
                    if (held_valid) begin
                        held_valid_n = 1'b0;
                        start_valid  = 1'b1;
                        start_addr   = held_addr;
                        start_data   = held_data;
                    end else if (!dl_req) begin
                        done_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (start_valid) begin
            if (start_addr[1]) begin
                wr_word_n = start_addr[24:2];
                wr_sel_n  = 4'b1100;
                wr_dat_n  = {start_data, start_data};
                state_n   = WRITE;
            end else begin
                half_word_n = start_addr[24:2];
                low_half_n  = start_data;
                state_n     = HALF;
            end
        end

        // Ownership is only taken between core cycles; a half-finished image also needs it
        dl_active_n = dl_active;
        if (!dl_active) begin
            dl_active_n = !core_cyc && (dl_req || (state != IDLE));
        end else if (!dl_req && (state == IDLE)) begin
            dl_active_n = 1'b0;
        end

        wait_n = (state_n == WRITE) || ((state_n == HALF) && !dl_active_n);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            low_half   <= '0;
            half_word  <= '0;
            wr_word    <= '0;
            wr_sel     <= '0;
            wr_dat     <= '0;
            held_valid <= 1'b0;
            held_addr  <= '0;
            held_data  <= '0;
            dl_active  <= 1'b0;
            ioctl_wait <= 1'b0;
            dl_done    <= 1'b0;
            dl_overrun <= 1'b0;
        end else begin
            state      <= state_n;
            low_half   <= low_half_n;
            half_word  <= half_word_n;
            wr_word    <= wr_word_n;
            wr_sel     <= wr_sel_n;
            wr_dat     <= wr_dat_n;
            held_valid <= held_valid_n;
            held_addr  <= held_addr_n;
            held_data  <= held_data_n;
            dl_active  <= dl_active_n;
            ioctl_wait <= wait_n;
            dl_done    <= done_n;
            if (ioctl_wr && ioctl_wait) begin
                dl_overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        ram_stb  = core_stb;
        ram_cyc  = core_cyc;
        ram_we   = core_we;
        ram_sel  = core_sel;
        ram_adr  = {core_adr, 2'b00};
        ram_dat  = core_dat;
        core_ack = ram_ack;
        if (dl_active) begin
            ram_stb  = (state == WRITE);
            ram_cyc  = (state == WRITE);
            ram_we   = (state == WRITE);
            ram_sel  = wr_sel;
            ram_adr  = loader_adr;
            ram_dat  = wr_dat;
            core_ack = 1'b0;
        end
    end

endmodule

// File: tb/tb_rom_loader_wb.sv
// tb_rom_loader_wb: directed bench with a halfword-packing reference model and an
// every-cycle compare process watching the shared SDRAM wishbone port.
module tb_rom_loader_wb;

    localparam int unsigned MAX_BYTES = 4194304;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic        ioctl_wait;
    logic        core_stb, core_cyc, core_we;
    logic [3:0]  core_sel;
    logic [23:0] core_adr;
    logic [31:0] core_dat;
    logic        core_ack;
    logic        ram_stb, ram_cyc, ram_we;
    logic [3:0]  ram_sel;
    logic [25:0] ram_adr;
    logic [31:0] ram_dat;
    logic        ram_ack;
    logic        dl_active, dl_done, dl_overrun;

    rom_loader_wb #(
        .DL_INDEX (8'd1),
        .BASE_ADDR(26'h400000),
        .MAX_BYTES(MAX_BYTES)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_index   (ioctl_index),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .ioctl_wait    (ioctl_wait),
        .core_stb      (core_stb),
        .core_cyc      (core_cyc),
        .core_we       (core_we),
        .core_sel      (core_sel),
        .core_adr      (core_adr),
        .core_dat      (core_dat),
        .core_ack      (core_ack),
        .ram_stb       (ram_stb),
        .ram_cyc       (ram_cyc),
        .ram_we        (ram_we),
        .ram_sel       (ram_sel),
        .ram_adr       (ram_adr),
        .ram_dat       (ram_dat),
        .ram_ack       (ram_ack),
        .dl_active     (dl_active),
        .dl_done       (dl_done),
        .dl_overrun    (dl_overrun)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [25:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } wb_t;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int done_cycle = 0;
    int ack_cycle = 0;
    int ack_latency = 2;
    bit check_en = 1'b0;
    logic [25:0] last_adr;
    logic [3:0]  last_sel;
    logic [31:0] last_dat;
    wb_t exp_q[$];

    logic        m_pend = 1'b0;
    logic [22:0] m_word = '0;
    logic [15:0] m_low = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] selMask(input logic [3:0] s);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{s[i]}};
        return m;
    endfunction

    function automatic void modelPush(input logic [22:0] w, input logic [3:0] s, input logic [31:0] d);
        wb_t t;
        t.adr = 26'(32'h400000 + 32'(w) * 4);
        t.sel = s;
        t.dat = d;
        exp_q.push_back(t);
    endfunction

    // Reference packing: pair halfwords of the same 32-bit word, flush loners as single halves
    function automatic void modelHalfword(input logic [24:0] a, input logic [15:0] d);
        logic [22:0] w;
        if (32'(a) >= MAX_BYTES) return;
        w = a[24:2];
        if (!a[1]) begin
            if (m_pend && m_word != w) modelPush(m_word, 4'b0011, {16'h0000, m_low});
            m_pend = 1'b1;
            m_word = w;
            m_low  = d;
        end else if (m_pend && m_word == w) begin
            modelPush(w, 4'b1111, {d, m_low});
            m_pend = 1'b0;
        end else begin
            if (m_pend) modelPush(m_word, 4'b0011, {16'h0000, m_low});
            modelPush(w, 4'b1100, {d, d});
            m_pend = 1'b0;
        end
    endfunction

    function automatic void modelEnd();
        if (m_pend) modelPush(m_word, 4'b0011, {16'h0000, m_low});
        m_pend = 1'b0;
    endfunction

    // SDRAM responder: acks a strobed cycle after ack_latency sampled cycles
    initial begin
        int busy;
        busy = 0;
        ram_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (ram_ack) begin
                ram_ack = 1'b0;
                busy = 0;
            end else if (ram_stb && ram_cyc) begin
                busy++;
                if (busy >= ack_latency) ram_ack = 1'b1;
            end else begin
                busy = 0;
            end
        end
    end

    // Every-cycle compare against passthrough rules and the expected write queue
    logic        p_stb = 1'b0, p_ack = 1'b0, p_done = 1'b0;
    logic [25:0] p_adr;
    logic [3:0]  p_sel;
    logic [31:0] p_dat;
    initial begin
        wb_t e;
        forever begin
            @(negedge clk_sys);
            #2;
            cycle++;
            if (check_en && !reset) begin
                if (!dl_active) begin
                    checkOutput("passthru_ctl", {27'd0, ram_stb, ram_cyc, ram_we, core_ack, ram_sel != core_sel},
                                {27'd0, core_stb, core_cyc, core_we, ram_ack, 1'b0});
                    checkOutput("passthru_adr", {6'd0, ram_adr}, {6'd0, core_adr, 2'b00});
                    checkOutput("passthru_dat", ram_dat, core_dat);
                end else begin
                    checkOutput("core_ack_blocked", {31'd0, core_ack}, 32'd0);
                    if (ram_stb) begin
                        checkOutput("ram_cyc_we", {30'd0, ram_cyc, ram_we}, 32'd3);
                        if (p_stb && !p_ack) begin
                            checkOutput("hold_adr", {6'd0, ram_adr}, {6'd0, p_adr});
                            checkOutput("hold_sel_dat", ram_dat ^ {28'd0, ram_sel}, p_dat ^ {28'd0, p_sel});
                        end
                        if (ram_ack) begin
                            wr_cnt++;
                            ack_cycle = cycle;
                            last_adr = ram_adr;
                            last_sel = ram_sel;
                            last_dat = ram_dat;
                            if (exp_q.size() == 0) begin
                                checkOutput("unexpected_write", {6'd0, ram_adr}, 32'hFFFFFFFF);
                            end else begin
                                e = exp_q.pop_front();
                                checkOutput("write_adr", {6'd0, ram_adr}, {6'd0, e.adr});
                                checkOutput("write_sel", {28'd0, ram_sel}, {28'd0, e.sel});
                                checkOutput("write_dat", ram_dat & selMask(e.sel), e.dat & selMask(e.sel));
                            end
                        end
                    end
                end
                if (dl_done) begin
                    done_cnt++;
                    done_cycle = cycle;
                    checkOutput("done_width", {31'd0, p_done}, 32'd0);
                end
            end
            p_stb  = dl_active && ram_stb;
            p_ack  = ram_ack;
            p_adr  = ram_adr;
            p_sel  = ram_sel;
            p_dat  = ram_dat;
            p_done = dl_done;
        end
    end

    // Drives one ioctl cycle; caller is aligned just after a rising edge
    task automatic applyStimulus(input logic wr, input logic [24:0] a, input logic [15:0] d);
        ioctl_wr   = wr;
        ioctl_addr = a;
        ioctl_dout = d;
        @(posedge clk_sys);
        #1;
        ioctl_wr = 1'b0;
    endtask

    task automatic hpsWrite(input logic [24:0] a, input logic [15:0] d);
        int n;
        n = 0;
        while (ioctl_wait && n < 100) begin
            @(posedge clk_sys);
            #1;
            n++;
        end
        checkOutput("hps_wait_bound", {31'd0, ioctl_wait}, 32'd0);
        applyStimulus(1'b1, a, d);
        modelHalfword(a, d);
    endtask

    task automatic startDownload(input logic [7:0] idx);
        ioctl_index = idx;
        ioctl_download = 1'b1;
        repeat (2) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic drainWrites();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ioctl_wait) && n < 200) begin
            @(posedge clk_sys);
            #1;
            n++;
        end
        checkOutput("drain_queue", exp_q.size(), 0);
    endtask

    task automatic endDownload();
        int n;
        n = 0;
        ioctl_download = 1'b0;
        modelEnd();
        while ((exp_q.size() != 0 || dl_active) && n < 200) begin
            @(posedge clk_sys);
            #1;
            n++;
        end
        checkOutput("release_queue", exp_q.size(), 0);
        checkOutput("release_active", {31'd0, dl_active}, 32'd0);
    endtask

    task automatic coreWrite(input logic [23:0] a, input logic [31:0] d, output bit got);
        core_adr = a;
        core_dat = d;
        core_sel = 4'hF;
        core_we  = 1'b1;
        core_cyc = 1'b1;
        core_stb = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(posedge clk_sys);
            #1;
            if (core_ack) got = 1'b1;
            else checkOutput("core_no_grab", {31'd0, dl_active}, 32'd0);
        end
    endtask

    task automatic coreRelease();
        core_cyc = 1'b0;
        core_stb = 1'b0;
        core_we  = 1'b0;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit got;
        int w0, d0, n;
        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index = 8'd0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        core_stb = 1'b0;
        core_cyc = 1'b0;
        core_we = 1'b0;
        core_sel = '0;
        core_adr = '0;
        core_dat = '0;
        repeat (3) @(posedge clk_sys);
        #1;
        checkOutput("rst_state", {26'd0, ioctl_wait, dl_active, dl_done, dl_overrun, ram_stb, ram_cyc}, 32'd0);
        reset = 1'b0;
        check_en = 1'b1;
        @(posedge clk_sys);
        #1;

        $display("[TB] test 1: paired halfwords");
        startDownload(8'd1);
        checkOutput("t1_active", {31'd0, dl_active}, 32'd1);
        w0 = wr_cnt;
        hpsWrite(25'h0, 16'h1234);
        hpsWrite(25'h2, 16'h5678);
        checkOutput("t1_wait_hi", {31'd0, ioctl_wait}, 32'd1);
        checkOutput("t1_stb", {31'd0, ram_stb}, 32'd1);
        n = 0;
        while (ioctl_wait && n < 20) begin
            @(posedge clk_sys);
            #1;
            n++;
        end
        checkOutput("t1_wait_cycles", n, 2);
        checkOutput("t1_adr", {6'd0, last_adr}, 32'h00400000);
        checkOutput("t1_sel", {28'd0, last_sel}, 32'hF);
        checkOutput("t1_dat", last_dat, 32'h56781234);
        checkOutput("t1_count", wr_cnt - w0, 1);
        endDownload();

        $display("[TB] test 2: flush on download end");
        startDownload(8'd1);
        d0 = done_cnt;
        hpsWrite(25'h0, 16'hAAAA);
        checkOutput("t2_half_quiet", {30'd0, ioctl_wait, ram_stb}, 32'd0);
        endDownload();
        checkOutput("t2_adr", {6'd0, last_adr}, 32'h00400000);
        checkOutput("t2_sel", {28'd0, last_sel}, 32'h3);
        checkOutput("t2_dat", {16'd0, last_dat[15:0]}, 32'h0000AAAA);
        checkOutput("t2_done_count", done_cnt - d0, 1);
        checkOutput("t2_done_time", done_cycle, ack_cycle + 1);

        $display("[TB] test 3: single high half and held slot");
        startDownload(8'd1);
        w0 = wr_cnt;
        hpsWrite(25'h6, 16'hBEEF);
        drainWrites();
        checkOutput("t3_hi_adr", {6'd0, last_adr}, 32'h00400004);
        checkOutput("t3_hi_sel", {28'd0, last_sel}, 32'hC);
        checkOutput("t3_hi_dat", last_dat, 32'hBEEFBEEF);
        hpsWrite(25'h0, 16'h1111);
        hpsWrite(25'h8, 16'h2222);
        checkOutput("t3_wait_held", {31'd0, ioctl_wait}, 32'd1);
        hpsWrite(25'hA, 16'h3333);
        drainWrites();
        checkOutput("t3_pair_adr", {6'd0, last_adr}, 32'h00400008);
        checkOutput("t3_pair_dat", last_dat, 32'h33332222);
        checkOutput("t3_count", wr_cnt - w0, 3);
        endDownload();

        $display("[TB] test 4: download waits for core cycle");
        ioctl_index = 8'd1;
        ioctl_download = 1'b1;
        coreWrite(24'h000123, 32'hCAFEF00D, got);
        checkOutput("t4_core_acked", {31'd0, got}, 32'd1);
        checkOutput("t4_core_adr", {6'd0, ram_adr}, 32'h0000048C);
        checkOutput("t4_no_grab", {31'd0, dl_active}, 32'd0);
        coreRelease();
        @(posedge clk_sys);
        #1;
        checkOutput("t4_grab", {31'd0, dl_active}, 32'd1);
        hpsWrite(25'h10, 16'hA1A1);
        hpsWrite(25'h12, 16'hB2B2);
        endDownload();

        $display("[TB] test 5: overrun and window limit");
        startDownload(8'd1);
        checkOutput("t5_overrun_clear", {31'd0, dl_overrun}, 32'd0);
        w0 = wr_cnt;
        hpsWrite(25'h2, 16'h5555);
        applyStimulus(1'b1, 25'h4, 16'h6666);
        checkOutput("t5_overrun", {31'd0, dl_overrun}, 32'd1);
        drainWrites();
        checkOutput("t5_count", wr_cnt - w0, 1);
        hpsWrite(25'h400000, 16'h7777);
        checkOutput("t5_max_quiet", {30'd0, ioctl_wait, ram_stb}, 32'd0);
        hpsWrite(25'h3FFFFE, 16'h8888);
        drainWrites();
        checkOutput("t5_top_adr", {6'd0, last_adr}, 32'h007FFFFC);
        checkOutput("t5_top_count", wr_cnt - w0, 2);
        endDownload();

        $display("[TB] test 6: reset mid-write and foreign index");
        ack_latency = 8;
        startDownload(8'd1);
        hpsWrite(25'h2, 16'h1234);
        @(posedge clk_sys);
        #1;
        checkOutput("t6_stb_before", {31'd0, ram_stb}, 32'd1);
        reset = 1'b1;
        @(posedge clk_sys);
        #1;
        checkOutput("t6_after_reset", {27'd0, ram_stb, ram_cyc, ioctl_wait, dl_active, dl_overrun}, 32'd0);
        exp_q.delete();
        m_pend = 1'b0;
        reset = 1'b0;
        ack_latency = 2;
        endDownload();
        w0 = wr_cnt;
        startDownload(8'd3);
        applyStimulus(1'b1, 25'h0, 16'h9999);
        coreWrite(24'h00ABCD, 32'h12345678, got);
        checkOutput("t6_core_acked", {31'd0, got}, 32'd1);
        checkOutput("t6_core_adr", {6'd0, ram_adr}, 32'h0002AF34);
        coreRelease();
        repeat (3) begin
            @(posedge clk_sys);
            #1;
        end
        checkOutput("t6_idx3_idle", {30'd0, dl_active, dl_overrun}, 32'd0);
        checkOutput("t6_idx3_count", wr_cnt - w0, 0);
        ioctl_download = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
